mem_ctrl_burst: RTL

- Byte-serial RAM controller arbitrating between the LSB (load/store) and the ICache (line refill).
- Successor to the single-word controller. Adds parametrised multi-word ICache line refill, explicit size/sign load extension, IO-store back-pressure and clear/abort of speculative reads.
- Sits between the memory bus (mem_din/mem_dout/mem_a/mem_wr) and the ICache/LSB.

---
 rtl/mem_ctrl_burst_if.sv | 31 +++
 rtl/mem_ctrl_burst.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_burst_if.sv
// ICache refill and LSB load/store handshake bundle for mem_ctrl_burst.
// master = requester side (ICache/LSB), slave = controller side.
interface mem_ctrl_burst_if #(
  parameter int unsigned IC_LINE_WORDS = 4
);
  logic                        ic_mem_ask;
  logic [31:0]                 ic_mem_addr;
  logic                        ic_mem_valid;
  logic [32*IC_LINE_WORDS-1:0] ic_mem_line;

  logic                        lsb_request;
  logic                        lsb_lors;
  logic [1:0]                  lsb_mem_size;
  logic                        lsb_mem_signed;
  logic [31:0]                 lsb_mem_addr;
  logic [31:0]                 lsb_mem_data;
  logic                        lsb_mem_valid;
  logic [31:0]                 lsb_mem_val;

  modport master (
    output ic_mem_ask, ic_mem_addr,
    output lsb_request, lsb_lors, lsb_mem_size, lsb_mem_signed, lsb_mem_addr, lsb_mem_data,
    input  ic_mem_valid, ic_mem_line, lsb_mem_valid, lsb_mem_val
  );

  modport slave (
    input  ic_mem_ask, ic_mem_addr,
    input  lsb_request, lsb_lors, lsb_mem_size, lsb_mem_signed, lsb_mem_addr, lsb_mem_data,
    output ic_mem_valid, ic_mem_line, lsb_mem_valid, lsb_mem_val
  );
endinterface

// File: rtl/mem_ctrl_burst.sv
// Byte-serial RAM controller arbitrating LSB load/store against ICache line refill.
// RAM returns the byte addressed in one cycle on mem_din in the following cycle.
// Optional macro MC_STARVE_GUARD_EN: after STARVE_LIMIT consecutive LSB grants made
// while the ICache is waiting, the next idle grant goes to the ICache.
module mem_ctrl_burst #(
  parameter int unsigned IC_LINE_WORDS = 4,
  parameter logic [1:0]  IO_HI_BITS    = 2'b11
`ifdef MC_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic [7:0]      mem_din,
  output logic [7:0]      mem_dout,
  output logic [31:0]     mem_a,
  output logic            mem_wr,
  input  logic            io_buffer_full,
  input  logic            clear_in,
  mem_ctrl_burst_if.slave bus
);
  localparam int unsigned B  = 4 * IC_LINE_WORDS;
  localparam int unsigned LW = 8 * B;
  localparam int unsigned CW = $clog2(B + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_STORE = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] nbytes;
  logic [CW-1:0] lsb_n;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic [LW-1:0] line_q;
  logic [LW-1:0] next_line;
  logic [31:0]   st_data;
  logic [31:0]   load_ext;
  logic [31:0]   fetch_base;
  logic          ic_valid;
  logic [LW-1:0] ic_line;
  logic          lsb_valid;
  logic [31:0]   lsb_val;
  logic          is_io;
  logic          lsb_ok;
  logic          ic_ok;
  logic          force_ic;
  logic          grant_lsb;
  logic          grant_ic;

  assign cnt_nx     = cnt + CW'(1);
  assign next_line  = {mem_din, line_q[LW-1:8]};
  assign fetch_base = bus.ic_mem_addr & ~32'(B - 1);

  assign bus.ic_mem_valid  = ic_valid;
  assign bus.ic_mem_line   = ic_line;
  assign bus.lsb_mem_valid = lsb_valid;
  assign bus.lsb_mem_val   = lsb_val;

  // Size/sign extension of the bytes collected at the top of the shift buffer.
  always_comb begin
    load_ext = next_line[LW-1 -: 32];
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & next_line[LW-1]}}, next_line[LW-1 -: 8]};
      2'b01:   load_ext = {{16{sgn_q & next_line[LW-1]}}, next_line[LW-1 -: 16]};
      default: ;
    endcase
  end

  // Idle arbitration: LSB first, IO stores held off by a full buffer, flush blocks reads.
  always_comb begin
    lsb_n = CW'(4);
    if (bus.lsb_mem_size == 2'b00)      lsb_n = CW'(1);
    else if (bus.lsb_mem_size == 2'b01) lsb_n = CW'(2);
    is_io     = (bus.lsb_mem_addr[17:16] == IO_HI_BITS);
    lsb_ok    = bus.lsb_request && (bus.lsb_lors ? !(is_io && io_buffer_full) : !clear_in);
    ic_ok     = bus.ic_mem_ask && !clear_in;
    grant_lsb = (state == S_IDLE) && lsb_ok && !force_ic;
    grant_ic  = (state == S_IDLE) && ic_ok && !grant_lsb;
  end

`ifdef MC_STARVE_GUARD_EN
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  logic [SCW-1:0] starve_cnt;

  // Count LSB grants that overtook a waiting ICache; any other grant clears the run.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      starve_cnt <= '0;
    end else if (rdy_in) begin
      if (grant_lsb)     starve_cnt <= bus.ic_mem_ask ? starve_cnt + SCW'(1) : '0;
      else if (grant_ic) starve_cnt <= '0;
    end
  end

  assign force_ic = (starve_cnt == SCW'(STARVE_LIMIT)) && bus.ic_mem_ask;
`else
  assign force_ic = 1'b0;
`endif

  // Main sequencer: byte-serial address/data stepping, capture and one-cycle valids.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      cnt       <= '0;
      nbytes    <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      line_q    <= '0;
      st_data   <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
      ic_valid  <= 1'b0;
      ic_line   <= '0;
      lsb_valid <= 1'b0;
      lsb_val   <= '0;
    end else if (rdy_in) begin
      ic_valid  <= 1'b0;
      lsb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_a    <= '0;
          mem_dout <= '0;
          mem_wr   <= 1'b0;
          cnt      <= '0;
          if (grant_lsb) begin
            size_q <= bus.lsb_mem_size;
            sgn_q  <= bus.lsb_mem_signed;
            nbytes <= lsb_n;
            mem_a  <= bus.lsb_mem_addr;
            if (bus.lsb_lors) begin
              state    <= S_STORE;
              mem_wr   <= 1'b1;
              mem_dout <= bus.lsb_mem_data[7:0];
              st_data  <= bus.lsb_mem_data >> 8;
            end else begin
              state <= S_LOAD;
            end
          end else if (grant_ic) begin
            nbytes <= CW'(B);
            mem_a  <= fetch_base;
            state  <= S_FETCH;
          end
        end
        S_LOAD, S_FETCH: begin
          if (clear_in) begin
            state <= S_IDLE;
            mem_a <= '0;
          end else begin
            cnt <= cnt_nx;
            // Bytes arrive one edge behind the address; the first edge has nothing to take.
            if (cnt != '0) line_q <= next_line;
            if (cnt_nx < nbytes) mem_a <= mem_a + 32'd1;
            else                 mem_a <= '0;
            if (cnt == nbytes) begin
              state <= S_DONE;
              if (state == S_FETCH) begin
                ic_valid <= 1'b1;
                ic_line  <= next_line;
              end else begin
                lsb_valid <= 1'b1;
                lsb_val   <= load_ext;
              end
            end
          end
        end
        S_STORE: begin
          cnt <= cnt_nx;
          if (cnt_nx < nbytes) begin
            mem_a    <= mem_a + 32'd1;
            mem_dout <= st_data[7:0];
            st_data  <= st_data >> 8;
          end else begin
            mem_wr    <= 1'b0;
            mem_a     <= '0;
            mem_dout  <= '0;
            lsb_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
